// File: rtl/slim_pkg.sv
// Shared constants and state encoding for the slime freeze scheduler.
// Hitbox geometry is in sprite pixels relative to top-left corners.
package slim_pkg;

    localparam int HIT_DX  = 24;
    localparam int SLIM_W  = 62;
    localparam int FEET_DY = 41;
    localparam int Y_TOL   = 2;
    localparam int MS_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FROZEN = 2'd2,
        ST_WARN   = 2'd3
    } slim_st_e;

endpackage

// File: rtl/slim_hit_cmp.sv
// Four-bound stomp comparator between the player's feet and one slime.
// All arithmetic is widened to 11 bits so nothing wraps.
module slim_hit_cmp
    import slim_pkg::*;
(
    input  logic [9:0] x_blue,
    input  logic [8:0] y_blue,
    input  logic [9:0] x_slim,
    input  logic [8:0] y_slim,
    output logic       hit
);

    logic [10:0] px;
    logic [10:0] sx;
    logic [10:0] sx_end;
    logic [10:0] py;
    logic [10:0] sy;

    assign px     = {1'b0, x_blue} + 11'(HIT_DX);
    assign sx     = {1'b0, x_slim};
    assign sx_end = sx + 11'(SLIM_W);
    assign py     = {2'b0, y_blue} + 11'(FEET_DY);
    assign sy     = {2'b0, y_slim};

    // Lower y bound adds the tolerance on the feet side to avoid underflow.
    assign hit = (px > sx) && (px < sx_end) &&
                 (py < sy + 11'(Y_TOL)) &&
                 (py + 11'(Y_TOL) > sy);

endmodule

// File: rtl/slim_freeze_sched.sv
// Round-robin freeze controller: one shared hit comparator scans the
// slime slots; each slot owns a millisecond freeze timer and state.
module slim_freeze_sched
    import slim_pkg::*;
#(
    parameter int N         = 4,
    parameter int TICK_DIV  = 25000,
    parameter int FREEZE_MS = 3000,
    parameter int WARN_MS   = 500,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [9:0]      x_blue,
    input  logic [8:0]      y_blue,
    input  logic [10*N-1:0] x_slim,
    input  logic [9*N-1:0]  y_slim,
    input  logic [N-1:0]    slim_alive,
    output logic [N-1:0]    frozen,
    output logic [N-1:0]    thaw_warn,
    output logic            freeze_evt,
    output logic [IW-1:0]   freeze_id
);

    logic [IW-1:0] scan_idx;
    logic [PW-1:0] presc;
    logic          ms_tick;
    logic          hit;
    logic          hit_r;
    logic [IW-1:0] hit_id;
    logic [N-1:0]  take_v;
    logic [9:0]    xs_arr [N];
    logic [8:0]    ys_arr [N];

    assign ms_tick = (presc == PW'(TICK_DIV - 1));

    slim_hit_cmp u_cmp (
        .x_blue (x_blue),
        .y_blue (y_blue),
        .x_slim (xs_arr[scan_idx]),
        .y_slim (ys_arr[scan_idx]),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx   <= '0;
            presc      <= '0;
            hit_r      <= 1'b0;
            hit_id     <= '0;
            freeze_evt <= 1'b0;
            freeze_id  <= '0;
        end else begin
            if (scan_idx == IW'(N - 1))
                scan_idx <= '0;
            else
                scan_idx <= scan_idx + 1'b1;
            if (ms_tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;
            hit_r      <= hit;
            hit_id     <= scan_idx;
            freeze_evt <= |take_v;
            // Only the slot named by hit_id can take a hit.
            if (|take_v)
                freeze_id <= hit_id;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        slim_st_e          st;
        logic [MS_W-1:0]   tmr;

        assign xs_arr[k]    = x_slim[10*k +: 10];
        assign ys_arr[k]    = y_slim[9*k +: 9];
        assign take_v[k]    = hit_r && (hit_id == IW'(k)) &&
                              (st != ST_IDLE) && slim_alive[k];
        assign frozen[k]    = (st == ST_FROZEN) || (st == ST_WARN);
        assign thaw_warn[k] = (st == ST_WARN);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st  <= ST_IDLE;
                tmr <= '0;
            end else if (!slim_alive[k]) begin
                st  <= ST_IDLE;
                tmr <= '0;
            end else if (take_v[k]) begin
                // Reload beats a coincident ms tick.
                st  <= ST_FROZEN;
                tmr <= MS_W'(FREEZE_MS);
            end else begin
                unique case (st)
                    ST_IDLE:   st <= ST_ACTIVE;
                    ST_ACTIVE: st <= ST_ACTIVE;
                    ST_FROZEN: begin
                        if (ms_tick) begin
                            tmr <= tmr - 1'b1;
                            if (tmr == MS_W'(WARN_MS + 1))
                                st <= ST_WARN;
                        end
                    end
                    ST_WARN: begin
                        if (ms_tick) begin
                            tmr <= tmr - 1'b1;
                            if (tmr == MS_W'(1))
                                st <= ST_ACTIVE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slim_freeze_sched.sv
// Scoreboard bench for slim_freeze_sched: a ms-level reference model
// predicts freeze events and frozen/thaw_warn per slot.
module tb_slim_freeze_sched;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int FM = 10;
    localparam int WM = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [9:0]      x_blue = 10'd100;
    logic [8:0]      y_blue = 9'd200;
    logic [10*N-1:0] x_slim = '0;
    logic [9*N-1:0]  y_slim = {N{9'd500}};
    logic [N-1:0]    slim_alive = '0;
    logic [N-1:0]    frozen;
    logic [N-1:0]    thaw_warn;
    logic            freeze_evt;
    logic [1:0]      freeze_id;

    int errors = 0;
    int checks = 0;

    int rem [N];
    bit pres [N];
    bit ph;
    int pid;
    int cyc;
    int last_id;
    int exp_q [$];

    always #5 clk = ~clk;

    slim_freeze_sched #(
        .N(N), .TICK_DIV(TD), .FREEZE_MS(FM), .WARN_MS(WM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_blue     (x_blue),
        .y_blue     (y_blue),
        .x_slim     (x_slim),
        .y_slim     (y_slim),
        .slim_alive (slim_alive),
        .frozen     (frozen),
        .thaw_warn  (thaw_warn),
        .freeze_evt (freeze_evt),
        .freeze_id  (freeze_id)
    );

    function automatic bit hit_ref(int xb, int yb, int xs, int ys);
        return (xb + 24 > xs) && (xb + 24 < xs + 62) &&
               (yb + 41 < ys + 2) && (yb + 43 > ys);
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: evaluated at every rising edge from sampled inputs.
    task automatic model_step();
        bit tick;
        int k;
        if (!rst_n) begin
            for (int s = 0; s < N; s++) begin
                rem[s] = 0;
                pres[s] = 0;
            end
            ph = 0;
            pid = 0;
            cyc = 0;
            last_id = 0;
            exp_q.delete();
        end else begin
            tick = (cyc % TD) == TD - 1;
            k = cyc % N;
            for (int s = 0; s < N; s++) begin
                if (!slim_alive[s]) begin
                    rem[s] = 0;
                    pres[s] = 0;
                end else if (ph && pid == s && pres[s]) begin
                    rem[s] = FM;
                    exp_q.push_back(s);
                    last_id = s;
                end else begin
                    if (tick && rem[s] > 0) rem[s]--;
                    pres[s] = 1;
                end
            end
            ph = hit_ref(int'(x_blue), int'(y_blue),
                         int'(x_slim[k*10 +: 10]), int'(y_slim[k*9 +: 9]));
            pid = k;
            cyc++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares DUT outputs to the model away from the active edge.
    initial begin
        int ef;
        int ew;
        int id;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ef = 0;
            ew = 0;
            for (int s = 0; s < N; s++) begin
                if (rem[s] > 0) ef |= (1 << s);
                if (rem[s] > 0 && rem[s] <= WM) ew |= (1 << s);
            end
            chk("frozen", int'(frozen), ef);
            chk("thaw_warn", int'(thaw_warn), ew);
            chk("freeze_id_hold", int'(freeze_id), last_id);
            if (freeze_evt) begin
                if (exp_q.size() == 0) begin
                    chk("evt_spurious", 1, 0);
                end else begin
                    id = exp_q.pop_front();
                    chk("evt_id", int'(freeze_id), id);
                end
            end else if (exp_q.size() > 0) begin
                chk("evt_missing", 0, exp_q.size());
                exp_q.delete();
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic put(int s, int x, int y);
        x_slim[s*10 +: 10] = 10'(x);
        y_slim[s*9 +: 9] = 9'(y);
    endtask

    task automatic far(int s);
        put(s, 0, 500);
    endtask

    task automatic wait_thaw(int s);
        int i;
        for (i = 0; i < 100; i++) begin
            if (!frozen[s]) break;
            cycles(1);
        end
        chk("thaw_timeout", int'(frozen[s]), 0);
    endtask

    task automatic probe(string name, int s, int x, int y, int exp);
        put(s, x, y);
        cycles(N + 2);
        chk(name, int'(frozen[s]), exp);
        far(s);
        wait_thaw(s);
        cycles(2);
    endtask

    initial begin
        int i;
        int xb;
        int yb;
        int xs;
        int ys;
        int s;

        cycles(3);
        chk("reset_frozen", int'(frozen), 0);
        chk("reset_evt", int'(freeze_evt), 0);
        rst_n = 1'b1;
        slim_alive = '1;
        for (int j = 0; j < N; j++) far(j);
        cycles(8);

        // Single stomp on slot 1
        put(1, 80, 242);
        for (i = 0; i < 5; i++) begin
            cycles(1);
            if (frozen[1]) break;
        end
        chk("stomp_latency", int'(frozen[1]), 1);
        far(1);
        for (i = 0; i < 60; i++) begin
            if (thaw_warn[1]) break;
            cycles(1);
        end
        chk("warn_seen", int'(thaw_warn[1]), 1);
        wait_thaw(1);
        chk("warn_clear", int'(thaw_warn[1]), 0);

        // X boundaries: player feet x is 124
        probe("bx_eq_left", 2, 124, 242, 0);
        probe("bx_eq_right", 2, 62, 242, 0);
        probe("bx_in_left", 2, 123, 242, 1);
        probe("bx_in_right", 2, 63, 242, 1);

        // Y boundaries: player feet y is 41
        x_blue = 10'd100;
        y_blue = 9'd0;
        probe("by_zero", 3, 80, 0, 0);
        probe("by_low_edge", 3, 80, 39, 0);
        probe("by_low_in", 3, 80, 40, 1);
        probe("by_high_in", 3, 80, 42, 1);
        probe("by_high_edge", 3, 80, 43, 0);
        y_blue = 9'd200;

        // Refreeze during warn
        put(0, 80, 242);
        cycles(N + 2);
        far(0);
        for (i = 0; i < 60; i++) begin
            if (thaw_warn[0]) break;
            cycles(1);
        end
        chk("refreeze_warn", int'(thaw_warn[0]), 1);
        put(0, 80, 242);
        cycles(N + 2);
        far(0);
        chk("refreeze_warn_drop", int'(thaw_warn[0]), 0);
        chk("refreeze_frozen", int'(frozen[0]), 1);
        wait_thaw(0);

        // Simultaneous overlap of slots 0 and 3
        put(0, 80, 242);
        put(3, 80, 242);
        cycles(N + 1);
        far(0);
        far(3);
        wait_thaw(0);
        wait_thaw(3);

        // Kill slot 2 mid-freeze at several scan phases
        for (int off = 0; off < N; off++) begin
            put(2, 80, 242);
            cycles(N + 2 + off);
            slim_alive[2] = 1'b0;
            cycles(1);
            chk("kill_frozen", int'(frozen[2]), 0);
            far(2);
            cycles(3);
            slim_alive[2] = 1'b1;
            cycles(4);
        end

        // Reset mid-freeze
        put(2, 80, 242);
        cycles(N + 2);
        far(2);
        chk("pre_reset_frozen", int'(frozen[2]), 1);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        chk("mid_reset_frozen", int'(frozen), 0);
        cycles(8);
        chk("post_reset_idle", int'(frozen[2]), 0);
        put(2, 80, 242);
        cycles(N + 2);
        chk("post_reset_refreeze", int'(frozen[2]), 1);
        far(2);
        wait_thaw(2);

        // Randomized traffic near the hitbox edges
        for (i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                x_blue = 10'($urandom_range(0, 1023));
                y_blue = 9'($urandom_range(0, 470));
            end
            if ($urandom_range(0, 7) == 0) begin
                s = $urandom_range(0, N - 1);
                if ($urandom_range(0, 3) == 0) begin
                    far(s);
                end else begin
                    xb = int'(x_blue);
                    yb = int'(y_blue);
                    xs = xb + 24 - $urandom_range(0, 63);
                    ys = yb + 39 + $urandom_range(0, 4);
                    if (xs < 0) xs = 0;
                    if (xs > 1023) xs = 1023;
                    if (ys > 511) ys = 511;
                    put(s, xs, ys);
                end
            end
            if ($urandom_range(0, 63) == 0)
                slim_alive[$urandom_range(0, N - 1)] ^= 1'b1;
            rst_n = ($urandom_range(0, 999) != 0);
            cycles(1);
        end
        rst_n = 1'b1;
        cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
